// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from the shift-register FIFO and sends each one as a UART frame on tx
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_val,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int MB = DATA_WIDTH > STOP_BITS ? DATA_WIDTH : STOP_BITS;
  localparam int BW = $clog2(MB + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DMAX = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] SMAX = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitc;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic par, bit_end, last, tx_n;
  assign bit_end = cnt == CMAX;
  assign last    = state == STOP && bit_end && bitc == SMAX;
  assign busy    = state != IDLE;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next-state: a word waiting at the end of a frame starts the next one with no idle gap
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fifo_val ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = bit_end && bitc == DMAX ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_n = bit_end ? STOP : PARITY;
      STOP:    state_n = last ? (fifo_val ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // outputs: pop/done strobes plus the line level for the coming cycle, so tx can be registered
  always_comb begin
    done      = last && !reset;
    fifo_read = (state == IDLE || last) && fifo_val && !reset;
    shift_n   = fifo_read ? fifo_data : (state == DATA && bit_end) ? shift >> 1 : shift;
    tx_n      = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par : 1'b1;
  end
  // datapath: bit timing, data shifting, parity captured at the pop, registered line
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      bitc  <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      cnt   <= (state_n != state || bit_end || state == IDLE) ? '0 : cnt + 1'b1;
      bitc  <= state_n != state ? '0 : bit_end ? bitc + 1'b1 : bitc;
      shift <= shift_n;
      par   <= fifo_read ? (^fifo_data) ^ (PARITY_ODD != 0) : par;
      tx    <= tx_n;
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the shift-register FIFO. It pops one word at a time over the FIFO's read/val/dataout interface and serialises it onto a single UART-style line: start bit, data LSB first, optional parity, then stop bit(s). This is the byte-to-line egress path for buffered data.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and of the serial data field.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
fifo_val  input  1  FIFO holds a word; fifo_data is valid in the same cycle.
fifo_data  input  DATA_WIDTH  FIFO head word, combinational from the FIFO.
fifo_read  output  1  pop strobe to the FIFO; high for exactly one cycle per word consumed.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress (state != IDLE).
done  output  1  one-cycle pulse in the final cycle of a frame.

Behaviour:
- Reset: reset is synchronous and active-high; clock is clk. After reset: state=IDLE, tx=1, busy=0, done=0, fifo_read=0, bit and cycle counters=0, shift register=0.
- tx is registered.
- fifo_read and done are combinational from state, counters and fifo_val. No combinational path exists from fifo_data.
- States:
  - IDLE: tx=1. If fifo_val=1, then fifo_read=1, fifo_data is latched into the shift register at the edge, and the next state is START. If fifo_val=0, the block stays in IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After DATA_WIDTH bits the next state is PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: tx = XOR of all latched data bits, inverted when PARITY_ODD=1. Held for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Final STOP cycle, where cycle counter = CLKS_PER_BIT-1 on the last stop bit:
  - done=1.
  - If fifo_val=1: fifo_read=1, the next word is latched, and the next state is START. There is no idle gap between frames.
  - Otherwise the next state is IDLE.
- Timing:
  - Pop-to-start latency: tx goes low on the clk edge that performs the pop, and is observed low in the next cycle.
  - Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on every state change.
  - Bit counter is wide enough for max(DATA_WIDTH, STOP_BITS).
- fifo_read never asserts when fifo_val=0, and never asserts outside IDLE or the final STOP cycle. Underflow is therefore impossible.
- fifo_data is sampled only on the pop edge. Changes at any other time have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted at the reset edge. tx=1 in the next cycle, no done pulse, and the word in flight is discarded. fifo_read=0 while reset is high.
- Reset asserted in the same cycle as fifo_val=1 in IDLE: reset wins, so there is no pop and no capture.

Test Plan:
1. Single word, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; push 0xA5.
   - fifo_read pulses once.
   - tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total.
   - done pulses at cycle 40, then busy=0 and tx=1.
2. Back-to-back, same config; FIFO holds 0x01 and 0xFF.
   - fifo_read pulses exactly twice, 40 cycles apart.
   - The second start bit begins immediately after the first stop bit, with no high gap beyond 4 cycles.
   - done pulses twice; 80 cycles total.
3. Parity, PARITY_EN=1, CLKS_PER_BIT=4, data 0x07:
   - With PARITY_ODD=0, the parity bit is 1.
   - Repeat with PARITY_ODD=1: the parity bit is 0.
   - Frame length is 44 cycles in both cases.
4. STOP_BITS=2, CLKS_PER_BIT=4, data 0x00: tx stays high for 8 cycles after the last data bit, done pulses in cycle 44, and busy drops in the next cycle.
5. Empty FIFO: hold fifo_val=0 for 100 cycles after reset. tx=1, busy=0 and fifo_read=0 throughout.
6. Reset mid-DATA: pulse reset for 1 cycle during bit 3 of 0x5A.
   - tx=1, busy=0 and no done in the next cycle.
   - With fifo_val=1, the next pop occurs in the first cycle after reset deasserts, and the next frame is complete and correct.
